// File: rtl/debounce_scheduler_if.sv
// Signal bundle between the board-facing pins and the debounce scheduler.
// Handshake: there is no valid/ready pair here; `in` is a free-running level
// sampled every cycle, `out`/`busy`/`owner` are levels, and `rise`/`fall` are
// single-cycle pulses with no back-pressure, so consumers must catch them on
// the cycle they appear.
interface debounce_scheduler_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic [N-1:0]     in;
    logic [N-1:0]     out;
    logic [N-1:0]     rise;
    logic [N-1:0]     fall;
    logic             busy;
    logic [IDX_W-1:0] owner;

    // Pin/stimulus side: drives the raw levels, observes everything else.
    modport master (
        output in,
        input  out, rise, fall, busy, owner
    );

    // Debouncer side.
    modport slave (
        input  in,
        output out, rise, fall, busy, owner
    );
endinterface

// File: rtl/debounce_scheduler.sv
// N-channel debouncer sharing one WIDTH-bit settle timer. A round-robin
// scheduler hands the timer to one pending channel at a time; a change is
// accepted only if it holds for 2^WIDTH cycles while that channel owns the
// timer. The FSM state is visible on the busy output (high in TIMING).
module debounce_scheduler #(
    parameter int N     = 4,
    parameter int WIDTH = 20,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    debounce_scheduler_if.slave  bus
);
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_TIMING = 1'b1
    } state_t;

    // After reset the pointer sits on the last channel so channel 0 wins first.
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_sync0;
    logic [N-1:0]     r_sync1;
    logic [N-1:0]     r_out;
    logic [N-1:0]     r_rise;
    logic [N-1:0]     r_fall;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last;
    logic [WIDTH-1:0] r_cnt;

    logic [N-1:0]     w_pend;
    logic [N-1:0]     w_out_nxt;
    logic [N-1:0]     w_rise_nxt;
    logic [N-1:0]     w_fall_nxt;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [IDX_W-1:0] w_last_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_pick;
    logic             w_found;

    // A channel is pending whenever its synchronized level disagrees with the
    // debounced level; it clears by itself if the input reverts.
    assign w_pend = r_sync1 ^ r_out;

    // Two-flop synchronizer for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= bus.in;
            r_sync1 <= r_sync0;
        end
    end

    // Round-robin search: first pending channel after the last grant, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IDX_W'((int'(r_last) + k) % N);
            if (!w_found && w_pend[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Scheduler next-state and output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_owner_nxt = w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_TIMING;
                end
            end
            ST_TIMING: begin
                if (!w_pend[r_owner]) begin
                    // Input bounced back before settling: drop the grant.
                    w_state_nxt = ST_IDLE;
                end else if (&r_cnt) begin
                    // Held for the full window: accept the new level.
                    w_out_nxt[r_owner] = ~r_out[r_owner];
                    if (r_out[r_owner]) begin
                        w_fall_nxt[r_owner] = 1'b1;
                    end else begin
                        w_rise_nxt[r_owner] = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over a same-cycle expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_owner <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.out   = r_out;
    assign bus.rise  = r_rise;
    assign bus.fall  = r_fall;
    assign bus.busy  = (r_state == ST_TIMING);
    assign bus.owner = r_owner;
endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N=4, WIDTH=4 (16-cycle window).
// Every rise/fall pulse is predicted at stimulus time as {cycle, fall, channel}
// and matched in order by a monitor; levels are spot-checked in the sequence.
module tb_debounce_scheduler;
    localparam int N     = 4;
    localparam int WIDTH = 4;
    localparam int IDX_W = 2;
    localparam int W     = 32;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;
    logic [W-1:0] exp_q[$];

    debounce_scheduler_if #(.N(N), .IDX_W(IDX_W)) bus_if ();

    debounce_scheduler #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    // Clock and cycle counter (cyc = number of rising edges seen).
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ev(input int c, input bit is_fall, input int ch);
        logic [26:0] cc;
        logic [3:0]  chh;
        cc  = 27'(c);
        chh = 4'(ch);
        return {cc, is_fall, chh};
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every pulse must be one-hot and match the next predicted event.
    initial begin
        logic [N-1:0] w;
        logic [W-1:0] exp_v;
        int           ch;
        forever begin
            @(negedge clk);
            w = bus_if.rise | bus_if.fall;
            if (w != '0) begin
                chk("pulse_onehot", {31'd0, $onehot(w)}, 32'd1);
                ch = 0;
                for (int i = 0; i < N; i++) if (w[i]) ch = i;
                chk("event_was_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    chk("event", ev(cyc, (bus_if.fall != '0), ch), exp_v);
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        int c;
        int d;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus_if.in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_out",   32'(bus_if.out),   32'd0);
        chk("rst_rise",  32'(bus_if.rise),  32'd0);
        chk("rst_fall",  32'(bus_if.fall),  32'd0);
        chk("rst_busy",  32'(bus_if.busy),  32'd0);
        chk("rst_owner", 32'(bus_if.owner), 32'd0);

        // Contention: all four pressed together, granted 0,1,2,3, 17 cycles apart.
        @(negedge clk);
        c = cyc;
        bus_if.in = 4'b1111;
        exp_q.push_back(ev(c + 19, 1'b0, 0));
        exp_q.push_back(ev(c + 36, 1'b0, 1));
        exp_q.push_back(ev(c + 53, 1'b0, 2));
        exp_q.push_back(ev(c + 70, 1'b0, 3));
        wait_until(c + 3);
        chk("cont_busy0",  32'(bus_if.busy),  32'd1);
        chk("cont_owner0", 32'(bus_if.owner), 32'd0);
        wait_until(c + 19);
        chk("cont_idle_gap", 32'(bus_if.busy), 32'd0);
        wait_until(c + 20);
        chk("cont_owner1", 32'(bus_if.owner), 32'd1);
        wait_until(c + 71);
        chk("cont_out", 32'(bus_if.out), 32'hF);

        // Fairness/release: ch2 released first, then ch0 and ch3 during its window.
        c = cyc;
        bus_if.in[2] = 1'b0;
        exp_q.push_back(ev(c + 19, 1'b1, 2));
        wait_until(c + 3);
        chk("rr_owner2", 32'(bus_if.owner), 32'd2);
        wait_until(c + 5);
        bus_if.in[0] = 1'b0;
        bus_if.in[3] = 1'b0;
        exp_q.push_back(ev(c + 36, 1'b1, 3));
        exp_q.push_back(ev(c + 53, 1'b1, 0));
        wait_until(c + 20);
        chk("rr_owner3", 32'(bus_if.owner), 32'd3);
        wait_until(c + 37);
        chk("rr_owner0", 32'(bus_if.owner), 32'd0);
        wait_until(c + 54);
        chk("rr_out", 32'(bus_if.out), 32'h2);

        // Release ch1 so every output is low again.
        c = cyc;
        bus_if.in[1] = 1'b0;
        exp_q.push_back(ev(c + 19, 1'b1, 1));
        wait_until(c + 20);
        chk("rel_out", 32'(bus_if.out), 32'h0);

        // Bounce: ch1 high for 8 cycles then low; timer aborts, no pulse.
        c = cyc;
        bus_if.in[1] = 1'b1;
        wait_until(c + 8);
        bus_if.in[1] = 1'b0;
        wait_until(c + 10);
        chk("bnc_busy_hi", 32'(bus_if.busy),  32'd1);
        chk("bnc_owner",   32'(bus_if.owner), 32'd1);
        wait_until(c + 11);
        chk("bnc_busy_lo", 32'(bus_if.busy),  32'd0);
        wait_until(c + 40);
        chk("bnc_out", 32'(bus_if.out), 32'h0);

        // Single press on ch0: busy for exactly 16 cycles, out toggles at +19.
        c = cyc;
        bus_if.in = 4'b0001;
        exp_q.push_back(ev(c + 19, 1'b0, 0));
        wait_until(c + 3);
        chk("sp_busy_start", 32'(bus_if.busy),  32'd1);
        chk("sp_owner",      32'(bus_if.owner), 32'd0);
        wait_until(c + 18);
        chk("sp_busy_end", 32'(bus_if.busy), 32'd1);
        chk("sp_out_pre",  32'(bus_if.out),  32'h0);
        wait_until(c + 19);
        chk("sp_busy_off", 32'(bus_if.busy), 32'd0);
        chk("sp_out_post", 32'(bus_if.out),  32'h1);

        // Reset mid-TIMING on a ch1 press while out[0]=1: no pulse, all cleared.
        c = cyc;
        bus_if.in = 4'b0011;
        wait_until(c + 13);
        chk("mid_owner", 32'(bus_if.owner), 32'd1);
        chk("mid_busy",  32'(bus_if.busy),  32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_out",   32'(bus_if.out),   32'h0);
        chk("mid_rst_busy",  32'(bus_if.busy),  32'd0);
        chk("mid_rst_owner", 32'(bus_if.owner), 32'd0);
        chk("mid_rst_pulse", 32'(bus_if.rise | bus_if.fall), 32'd0);
        reset = 1'b0;
        d = cyc;
        exp_q.push_back(ev(d + 19, 1'b0, 0));
        exp_q.push_back(ev(d + 36, 1'b0, 1));
        wait_until(d + 18);
        chk("post_rst_pre", 32'(bus_if.out), 32'h0);
        wait_until(d + 37);
        chk("post_rst_out", 32'(bus_if.out), 32'h3);

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces N raw push-button/switch inputs using a single shared WIDTH-bit settle timer instead of one counter per input.
- A round-robin scheduler grants the timer to one pending channel at a time.
- Produces debounced levels plus one-cycle rise/fall event pulses for downstream control logic.
- Sits between the board-level button/switch pins and the core's control/status logic.

Parameters:
- N, 4: number of input channels (2..16).
- WIDTH, 20: settle-timer width; a change must hold for 2^WIDTH cycles.
- IDX_W, 2: owner index width; must satisfy 2^IDX_W >= N.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in  input  N  raw asynchronous button/switch levels.
- out  output  N  debounced levels, registered.
- rise  output  N  one-cycle pulse when out[i] goes 0->1.
- fall  output  N  one-cycle pulse when out[i] goes 1->0.
- busy  output  1  high while the timer is owned (state TIMING).
- owner  output  IDX_W  channel currently owning the timer; holds its last value when idle.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state updates occur on the rising edge of clk.
- Reset values: out, rise, fall, busy, owner, counter and both synchronizer stages are 0; the FSM is IDLE; the round-robin pointer last = N-1, so channel 0 has first priority.
- Synchronizer: each in[i] passes through 2 flops to form s[i]. The raw-to-s latency is 2 cycles.
- Pending: pend[i] = s[i] XOR out[i] (combinational).
- Scheduler FSM, 2 states:
  - IDLE: if any pend bit is set, pick the first pending index searching last+1, last+2, … modulo N. Set owner to that index, last to that index, counter to 0, and go to TIMING. If nothing is pending, stay in IDLE.
  - TIMING:
    - Abort: if pend[owner] == 0 (input bounced back), go to IDLE. No out change, no pulse.
    - Expiry: else if counter is all-ones, toggle out[owner], assert rise[owner] or fall[owner] for exactly that cycle, and go to IDLE.
    - Otherwise: increment the counter.
- Latency: if s[i] changes at edge t, the timer is idle and i wins the grant, then TIMING is entered at t+1 and out[i] toggles at edge t+1+2^WIDTH. Raw pin to out is therefore 2^WIDTH+3 cycles.
- Boundary conditions:
  - Non-owners: channels that change while the timer is busy stay pending and are not timed. If a non-owner's input reverts before its grant, its pending bit clears and it is never granted.
  - At most one out bit changes per cycle, and at most one rise/fall bit is set per cycle.
  - The IDLE cycle between grants is mandatory; back-to-back grants are separated by at least 1 IDLE cycle.
  - Fairness: with all N channels continuously pending, each is granted exactly once per N grants.
  - Reset: reset asserted mid-TIMING returns everything to reset values on the next edge, with no pulse. Reset has priority over expiry.
  - Counter: never wraps in TIMING, because expiry leaves the state.

Test Plan (N=4, WIDTH=4, expiry after 16 TIMING cycles):
- Single press: in=4'b0001 held from cycle 0 -> out[0]=1 and rise[0]=1 for exactly one cycle at raw+19; busy high for 16 cycles; owner=0.
- Bounce: in[1] high for 8 cycles, then low -> abort; out[1] stays 0, rise never asserts; busy drops 1 cycle after s[1] falls.
- Contention: in=4'b1111 together -> rises in order 0,1,2,3, each 17 cycles apart; never two rise bits in the same cycle.
- Round-robin fairness: ch2 granted; ch0 and ch3 become pending during its TIMING -> next grant is ch3, then ch0.
- Release: out[2]=1, then in[2]=0 held -> fall[2] pulses once after 16 TIMING cycles; out[2]=0.
- Reset mid-operation: reset asserted at count 10 during a ch1 press -> next edge: out=0, busy=0, owner=0, no pulse; after reset deasserts with in[1] still high, a full 16-cycle timing restarts.
